// File: rtl/spio_pkg.sv
// Shared register map, control-bit layout and version for the simple peripheral I/O block.
package spio_pkg;

    localparam logic [1:0] ADDR_LED  = 2'd0;
    localparam logic [1:0] ADDR_BTN  = 2'd1;
    localparam logic [1:0] ADDR_SW   = 2'd2;
    localparam logic [1:0] ADDR_CTRL = 2'd3;

    localparam int CTRL_DEMO   = 0;
    localparam int CTRL_BTN_IE = 1;
    localparam int CTRL_SW_IE  = 2;
    localparam int CTRL_EDGE   = 3;

    localparam logic [15:0] SPIO_VERSION = 16'h0002;

    // Packed so that demo lands in bit 0, matching the CTRL register layout.
    typedef struct packed {
        logic edge_mode;
        logic sw_ie;
        logic btn_ie;
        logic demo;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{edge_mode: 1'b0, sw_ie: 1'b0, btn_ie: 1'b0, demo: 1'b1};

endpackage

// File: rtl/spio_debounce.sv
// Per-bit synchroniser plus counter debouncer; emits the stable level and one-cycle edge pulses.
module spio_debounce #(
    parameter int WIDTH    = 8,
    parameter int NFF      = 2,
    parameter int DEBOUNCE = 100000
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [WIDTH-1:0] i_raw,
    output logic [WIDTH-1:0] o_level,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
);

    localparam int            CW       = $clog2(DEBOUNCE);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [NFF-1:0] sync;
        logic [CW-1:0]  cnt;
        logic           lvl, rise, fall;

        // Counter tracks consecutive samples disagreeing with the level; any agreement restarts it.
        always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                sync <= '0;
                cnt  <= '0;
                lvl  <= 1'b0;
                rise <= 1'b0;
                fall <= 1'b0;
            end else begin
                sync <= {sync[NFF-2:0], i_raw[i]};
                rise <= 1'b0;
                fall <= 1'b0;
                if (sync[NFF-1] == lvl) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    lvl  <= ~lvl;
                    cnt  <= '0;
                    rise <= ~lvl;
                    fall <= lvl;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end

        assign o_level[i] = lvl;
        assign o_rise[i]  = rise;
        assign o_fall[i]  = fall;
    end

endmodule

// File: rtl/spio_deb.sv
// Wishbone LED/button/switch peripheral: masked LED writes, W1C event latches, demo pattern, interrupt.
module spio_deb
    import spio_pkg::*;
#(
    parameter int NLEDS     = 8,
    parameter int NBTN      = 8,
    parameter int NSW       = 8,
    parameter int NFF       = 2,
    parameter int DEBOUNCE  = 100000,
    parameter int DEMO_LOG2 = 22
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_wb_cyc,
    input  logic             i_wb_stb,
    input  logic             i_wb_we,
    input  logic [1:0]       i_wb_addr,
    input  logic [31:0]      i_wb_data,
    input  logic [3:0]       i_wb_sel,
    output logic             o_wb_stall,
    output logic             o_wb_ack,
    output logic [31:0]      o_wb_data,
    input  logic [NBTN-1:0]  i_btn,
    input  logic [NSW-1:0]   i_sw,
    output logic [NLEDS-1:0] o_led,
    output logic             o_int
);

    ctrl_t                ctrl;
    logic [NLEDS-1:0]     led_reg, led_nxt, pat;
    logic                 dir_down;
    logic [DEMO_LOG2-1:0] presc;
    logic [NBTN-1:0]      btn_lvl, btn_rise, btn_fall, btn_latch, btn_clr;
    logic [NSW-1:0]       sw_lvl, sw_rise, sw_fall, sw_latch, sw_clr;
    logic                 req, wr;
    logic [15:0]          lo_be, hi_be, mask, eff;
    logic [31:0]          rdata;

    assign req        = i_wb_cyc & i_wb_stb;
    assign wr         = req & i_wb_we;
    assign o_wb_stall = 1'b0;

    spio_debounce #(.WIDTH(NBTN), .NFF(NFF), .DEBOUNCE(DEBOUNCE)) u_btn (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_raw(i_btn),
        .o_level(btn_lvl), .o_rise(btn_rise), .o_fall(btn_fall)
    );

    spio_debounce #(.WIDTH(NSW), .NFF(NFF), .DEBOUNCE(DEBOUNCE)) u_sw (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_raw(i_sw),
        .o_level(sw_lvl), .o_rise(sw_rise), .o_fall(sw_fall)
    );

    // An all-zero (or byte-disabled) mask means a plain write of the enabled low lanes.
    always_comb begin
        lo_be   = {{8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};
        hi_be   = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}}};
        mask    = i_wb_data[31:16] & hi_be;
        eff     = (mask == 16'h0) ? lo_be : (mask & lo_be);
        led_nxt = NLEDS'((16'(led_reg) & ~eff) | (i_wb_data[15:0] & eff));
        btn_clr = '0;
        sw_clr  = '0;
        if (wr && i_wb_addr == ADDR_BTN) btn_clr = i_wb_data[NBTN-1:0] & lo_be[NBTN-1:0];
        if (wr && i_wb_addr == ADDR_SW)  sw_clr  = i_wb_data[16 +: NSW] & hi_be[NSW-1:0];
    end

    always_comb begin
        rdata = '0;
        case (i_wb_addr)
            ADDR_LED: rdata[15:0] = 16'(led_reg);
            ADDR_BTN: rdata = {16'(btn_lvl), 16'(btn_latch)};
            ADDR_SW:  rdata = {16'(sw_latch), 16'(sw_lvl)};
            default:  rdata = {SPIO_VERSION, 12'h0, ctrl};
        endcase
    end

    // Edge set is OR'd after the clear so a coincident W1C never loses a fresh event.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_wb_ack  <= 1'b0;
            o_wb_data <= '0;
            led_reg   <= '0;
            ctrl      <= CTRL_RESET;
            btn_latch <= '0;
            sw_latch  <= '0;
            o_int     <= 1'b0;
        end else begin
            o_wb_ack  <= req;
            o_wb_data <= req ? rdata : '0;
            if (wr && i_wb_addr == ADDR_LED) led_reg <= led_nxt;
            if (wr && i_wb_addr == ADDR_CTRL && i_wb_sel[0]) ctrl <= ctrl_t'(i_wb_data[3:0]);
            btn_latch <= (btn_latch & ~btn_clr) | btn_rise | (ctrl.edge_mode ? btn_fall : '0);
            sw_latch  <= (sw_latch & ~sw_clr) | sw_rise | sw_fall;
            o_int     <= (ctrl.btn_ie & |btn_latch) | (ctrl.sw_ie & |sw_latch);
        end
    end

    // Bouncing one-hot keeps running even while the LEDs show the register value.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            presc    <= '0;
            pat      <= NLEDS'(1);
            dir_down <= 1'b0;
            o_led    <= '0;
        end else begin
            presc <= presc + DEMO_LOG2'(1);
            o_led <= ctrl.demo ? pat : led_reg;
            if (&presc && NLEDS > 1) begin
                if (!dir_down) begin
                    if (pat[NLEDS-1]) begin
                        pat      <= pat >> 1;
                        dir_down <= 1'b1;
                    end else begin
                        pat <= pat << 1;
                    end
                end else if (pat[0]) begin
                    pat      <= pat << 1;
                    dir_down <= 1'b0;
                end else begin
                    pat <= pat >> 1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spio_deb.sv
// Directed plus randomized bench for spio_deb with a window-based debounce/latch reference model.
module tb_spio_deb;

    localparam int NLEDS = 8, NBTN = 8, NSW = 8, NFF = 2, DEB = 4, DL = 3;
    localparam int HN = 64;

    logic              clk = 1'b0, rst_n = 1'b0;
    logic              cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [1:0]        addr = '0;
    logic [31:0]       wdata = '0;
    logic [3:0]        sel = '0;
    logic              stall, ack, irq;
    logic [31:0]       rdata;
    logic [NBTN-1:0]   btn = '0;
    logic [NSW-1:0]    sw = '0;
    logic [NLEDS-1:0]  led;

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    spio_deb #(.NLEDS(NLEDS), .NBTN(NBTN), .NSW(NSW), .NFF(NFF), .DEBOUNCE(DEB), .DEMO_LOG2(DL)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr),
        .i_wb_data(wdata), .i_wb_sel(sel),
        .o_wb_stall(stall), .o_wb_ack(ack), .o_wb_data(rdata),
        .i_btn(btn), .i_sw(sw), .o_led(led), .o_int(irq)
    );

    // Reference: a button level flips once the last DEB synchronised samples all disagree with it.
    logic [NBTN-1:0] hist [HN];
    int              mcyc;
    logic [NBTN-1:0] m_lvl, m_pend, m_latch;
    logic [NBTN-1:0] m_clr = '0;
    logic            m_edge = 1'b0;
    logic [31:0]     snap;

    function automatic logic [NBTN-1:0] win_level();
        logic [NBTN-1:0] lv = m_lvl;
        for (int b = 0; b < NBTN; b++) begin
            bit all_diff = 1'b1;
            for (int j = NFF; j < NFF + DEB; j++)
                if (hist[(mcyc + HN - j) % HN][b] == m_lvl[b]) all_diff = 1'b0;
            if (all_diff) lv[b] = ~m_lvl[b];
        end
        return lv;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HN; i++) hist[i] <= '0;
            mcyc    <= 0;
            m_lvl   <= '0;
            m_pend  <= '0;
            m_latch <= '0;
        end else begin
            m_lvl   <= win_level();
            m_pend  <= (win_level() & ~m_lvl) | (m_edge ? (~win_level() & m_lvl) : '0);
            m_latch <= (m_latch & ~m_clr) | m_pend;
            hist[mcyc % HN] <= btn;
            mcyc    <= mcyc + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wb_wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = a; wdata = d; sel = s;
        if (a == 2'd1) m_clr = d[NBTN-1:0];
        if (a == 2'd3) m_edge = d[3];
        @(negedge clk);
        check("wr_ack", 32'(ack), 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; m_clr = '0;
    endtask

    task automatic wb_rd(input logic [1:0] a, output logic [31:0] d);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = a; sel = 4'hF;
        snap = {8'h0, m_lvl, 8'h0, m_latch};
        @(negedge clk);
        check("rd_ack", 32'(ack), 32'd1);
        d = rdata;
        cyc = 1'b0; stb = 1'b0;
    endtask

    function automatic logic [7:0] walk(input int idx);
        int p = idx % 14;
        int pos = (p < 8) ? p : 14 - p;
        return 8'(1 << pos);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v;
        logic        em;

        #1;
        check("rst_ack", 32'(ack), 0);
        check("rst_data", rdata, 0);
        check("rst_led", 32'(led), 0);
        check("rst_int", 32'(irq), 0);
        check("stall", 32'(stall), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Demo walk: one step every 2^DL cycles, bouncing at the ends.
        for (int j = 1; j <= 72; j++) begin
            @(negedge clk);
            if (j % 8 == 1) check("demo_walk", 32'(led), 32'(walk((j - 1) / 8)));
        end

        wb_rd(2'd0, v); check("rd_led_rst", v, 32'h0);
        wb_rd(2'd1, v); check("rd_btn_rst", v, 32'h0);
        wb_rd(2'd2, v); check("rd_sw_rst", v, 32'h0);
        wb_rd(2'd3, v); check("rd_ctrl_rst", v, 32'h00020001);
        @(negedge clk);
        check("idle_ack", 32'(ack), 0);
        check("idle_data", rdata, 0);

        // LED register writes: plain, masked, and mask ignored when its lanes are off.
        wb_wr(2'd3, 32'h0, 4'hF);
        wb_wr(2'd0, 32'h000000A5, 4'hF);
        check("led_demo_off", 32'(led), 0);
        tick(1); check("led_a5", 32'(led), 32'hA5);
        wb_wr(2'd0, 32'h000F0003, 4'hF);
        tick(1); check("led_masked", 32'(led), 32'hA3);
        wb_wr(2'd0, 32'h00FF0011, 4'h3);
        tick(1); check("led_sel3", 32'(led), 32'h11);
        wb_rd(2'd0, v); check("rd_led", v, 32'h11);

        // Short glitch is rejected; a held press rises exactly NFF+DEB cycles later.
        btn = 8'h04; tick(3); btn = 8'h00; tick(10);
        wb_rd(2'd1, v); check("glitch", v, 32'h0);
        btn = 8'h04;
        tick(5); check("lat_before", 32'(dut.u_btn.o_level[2]), 0);
        tick(1); check("lat_exact", 32'(dut.u_btn.o_level[2]), 1);
        tick(2);
        wb_rd(2'd1, v); check("btn_press", v, 32'h00040004);
        btn = 8'h00; tick(10);
        wb_wr(2'd1, 32'h4, 4'hF);
        wb_rd(2'd1, v); check("btn_cleared", v, 32'h0);

        // Button interrupt, then W1C racing a release edge in edge mode 1.
        wb_wr(2'd3, 32'h2, 4'hF);
        btn = 8'h01;
        tick(6); check("latch_pre", 32'(dut.btn_latch[0]), 0);
        tick(1); check("latch_set", 32'(dut.btn_latch[0]), 1);
        check("int_lag", 32'(irq), 0);
        tick(1); check("int_set", 32'(irq), 1);
        wb_wr(2'd1, 32'h1, 4'h1);
        check("int_hold", 32'(irq), 1);
        tick(1); check("int_clr", 32'(irq), 0);
        wb_wr(2'd3, 32'hA, 4'hF);
        btn = 8'h00;
        tick(6);
        wb_wr(2'd1, 32'h1, 4'h1);
        check("set_wins", 32'(dut.btn_latch[0]), 1);
        tick(1); check("int_release", 32'(irq), 1);
        wb_wr(2'd1, 32'h1, 4'h1);
        tick(1); check("int_clr2", 32'(irq), 0);

        // Switch change latch and its interrupt.
        wb_wr(2'd3, 32'h4, 4'hF);
        sw = 8'h20; tick(10);
        wb_rd(2'd2, v); check("sw_change", v, 32'h00200020);
        check("sw_int", 32'(irq), 1);
        wb_wr(2'd2, 32'h00200000, 4'hF);
        wb_rd(2'd2, v); check("sw_w1c", v, 32'h00000020);
        check("sw_int_clr", 32'(irq), 0);

        // Randomized button activity against the reference model.
        em = 1'($urandom_range(0, 1));
        wb_wr(2'd3, {28'h0, em, 3'b000}, 4'hF);
        for (int it = 0; it < 30; it++) begin
            btn = NBTN'($urandom);
            tick($urandom_range(1, 8));
            wb_rd(2'd1, v); check("rand_btn", v, snap);
            if ($urandom_range(0, 1) == 1) wb_wr(2'd1, $urandom & 32'hFF, 4'hF);
        end
        btn = '0; tick(12);
        wb_rd(2'd1, v); check("rand_final", v, snap);

        // Reset asserted while an ack is on the bus.
        sw = '0; tick(12);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 2'd3;
        @(posedge clk); #2;
        check("ack_pre_rst", 32'(ack), 1);
        rst_n = 1'b0; m_edge = 1'b0;
        #1;
        check("ack_async", 32'(ack), 0);
        check("led_async", 32'(led), 0);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        rst_n = 1'b1;
        wb_rd(2'd0, v); check("post_led", v, 32'h0);
        check("post_demo", 32'(led), 32'h01);
        wb_rd(2'd1, v); check("post_btn", v, 32'h0);
        wb_rd(2'd2, v); check("post_sw", v, 32'h0);
        wb_rd(2'd3, v); check("post_ctrl", v, 32'h00020001);
        check("post_int", 32'(irq), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
